// File: rtl/registerfile_param.sv
// registerfile_param: NUM_REGS x DATA_W register file for the ID stage.
// It has two combinational read ports with write-to-read bypass and one
// synchronous write port. Writes to out-of-range addresses, and writes made
// while the clear engine runs, are dropped and flagged on wr_drop. The bulk
// clear engine zeroes one register per cycle and reports progress on
// busy/clr_done.
// Optional build macro REGFILE_ZERO_REG_EN: register 0 is hardwired to zero.
module registerfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] controle,
  input  logic [DATA_W-1:0] entrada,
  input  logic              wr,
  input  logic              clr_req,
  output logic [DATA_W-1:0] saidaA,
  output logic [DATA_W-1:0] saidaB,
  output logic              busy,
  output logic              clr_done,
  output logic              wr_drop
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  // One extra bit so that NUM_REGS == 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0] NREGS_L = (ADDR_W+1)'(NUM_REGS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              clr_done_q, clr_done_d;
  logic              wr_drop_q, wr_drop_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  logic wr_in_range;
  logic wr_zero_addr;
  logic wr_accept;
  logic wr_discard;

  assign busy     = (state_q == CLEAR);
  assign clr_done = clr_done_q;
  assign wr_drop  = wr_drop_q;

  // Classify the write request of this cycle.
  always_comb begin
    wr_in_range = ({1'b0, controle} < NREGS_L);
`ifdef REGFILE_ZERO_REG_EN
    wr_zero_addr = (controle == '0);
`else
    wr_zero_addr = 1'b0;
`endif
    // Writes to a hardwired register 0 vanish without raising wr_drop.
    wr_accept  = wr && !busy && wr_in_range && !wr_zero_addr;
    wr_discard = wr && (busy || !wr_in_range) && !wr_zero_addr;
  end

  // Combinational read: out-of-range reads and a hardwired zero register
  // return 0; an accepted write to the same address is forwarded.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    val = '0;
    if ({1'b0, addr} < NREGS_L) begin
      val = regs_q[addr[IDX_W-1:0]];
    end
`ifdef REGFILE_ZERO_REG_EN
    if (addr == '0) begin
      val = '0;
    end
`endif
    if (wr_accept && (addr == controle)) begin
      val = entrada;
    end
    return val;
  endfunction

  // Drive both read ports.
  always_comb begin
    saidaA = read_port(rs);
    saidaB = read_port(rt);
  end

  // Next-state logic for the clear FSM and the register array.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    clr_done_d = 1'b0;
    wr_drop_d  = wr_discard;
    regs_d     = regs_q;
    unique case (state_q)
      IDLE: begin
        if (wr_accept) begin
          regs_d[controle[IDX_W-1:0]] = entrada;
        end
        if (clr_req) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        regs_d[idx_q] = '0;
        if (idx_q == LAST_IDX) begin
          state_d    = IDLE;
          idx_d      = '0;
          clr_done_d = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State registers; reset takes priority over writes and clear requests.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      clr_done_q <= 1'b0;
      wr_drop_q  <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      clr_done_q <= clr_done_d;
      wr_drop_q  <= wr_drop_d;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

endmodule
